lsu_master: RTL

- Load/store initiator driving the data-memory port of the unified main memory on behalf of the core's MEM stage.
- Accepts one byte/half/word load, store, or fence.i request at a time.
- Waits for the memory's ready signal, then generates word address, byte enables and lane-replicated write data.
- Extracts and sign/zero-extends read data one cycle after the read, flags misaligned accesses without touching memory, and sequences fence.i handshakes.

---
 rtl/lsu_master_if.sv | 43 ++++
 rtl/lsu_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lsu_master_if.sv
// Core request / response and data-memory port bundle for the load/store initiator.
// Latency: none, wiring only.
// Backpressure: o_req_ready towards the core, i_mem_ready from the memory.
interface lsu_master_if #(
    parameter int ADDR_W = 14
) ();
    // core request
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_fence;
    logic              i_req_we;
    logic [1:0]        i_req_size;
    logic              i_req_unsigned;
    logic [ADDR_W+1:0] i_req_addr;
    logic [31:0]       i_req_wdata;
    // core response
    logic              o_resp_valid;
    logic [31:0]       o_resp_rdata;
    logic              o_resp_misaligned;
    // data-memory port
    logic              o_dm_ren;
    logic              o_dm_wen;
    logic [3:0]        o_dm_ben;
    logic [ADDR_W-1:0] o_dm_addr;
    logic [31:0]       o_dm_wdata;
    logic [31:0]       i_dm_rdata;
    logic              o_fence_i;
    logic              i_mem_ready;

    modport master (
        input  i_req_valid, i_req_fence, i_req_we, i_req_size, i_req_unsigned,
               i_req_addr, i_req_wdata, i_dm_rdata, i_mem_ready,
        output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_misaligned,
               o_dm_ren, o_dm_wen, o_dm_ben, o_dm_addr, o_dm_wdata, o_fence_i
    );

    modport slave (
        output i_req_valid, i_req_fence, i_req_we, i_req_size, i_req_unsigned,
               i_req_addr, i_req_wdata, i_dm_rdata, i_mem_ready,
        input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_misaligned,
               o_dm_ren, o_dm_wen, o_dm_ben, o_dm_addr, o_dm_wdata, o_fence_i
    );
endinterface

// File: rtl/lsu_master.sv
// Load/store initiator for the data-memory port: aligns, issues, extends loads, sequences fence.i.
// Latency from accept with memory ready: misaligned T+1, store T+2, load T+3.
// Backpressure: one request in flight; stalls in ISSUE/FENCE states while i_mem_ready is low.
module lsu_master #(
    parameter int ADDR_W = 14
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    lsu_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RDATA,
        S_FENCE_ISSUE,
        S_FENCE_BUSY,
        S_FENCE_DONE,
        S_RESP
    } state_t;

    state_t            state;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [3:0]        ben_q;
    logic [31:0]       wdata_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_mis_q;
    logic [31:0]       resp_rdata_q;

    logic              issue_go;
    logic [31:0]       rd_lane;
    logic [31:0]       rd_ext;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_ben(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Narrow stores are replicated so the selected byte lanes carry the data wherever they sit.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Lane select and sign/zero extension of the returning read word.
    assign rd_lane = bus.i_dm_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        rd_ext = rd_lane;
        case (size_q)
            2'b00:   rd_ext = {{24{rd_lane[7] & ~uns_q}}, rd_lane[7:0]};
            2'b01:   rd_ext = {{16{rd_lane[15] & ~uns_q}}, rd_lane[15:0]};
            default: rd_ext = rd_lane;
        endcase
    end

    // Strobes fire only in the cycle the memory can take them, so they are gated by i_mem_ready.
    assign issue_go      = (state == S_ISSUE) && bus.i_mem_ready;
    assign bus.o_dm_wen  = issue_go && we_q;
    assign bus.o_dm_ren  = issue_go && !we_q;
    assign bus.o_dm_ben  = issue_go ? ben_q : 4'b0000;
    assign bus.o_fence_i = (state == S_FENCE_ISSUE) && bus.i_mem_ready;
    assign bus.o_dm_addr = addr_q[ADDR_W+1:2];
    assign bus.o_dm_wdata = wdata_q;

    assign bus.o_req_ready       = req_ready_q;
    assign bus.o_resp_valid      = resp_valid_q;
    assign bus.o_resp_rdata      = resp_rdata_q;
    assign bus.o_resp_misaligned = resp_mis_q;

    // Request sequencing FSM; response fields only change on the way into RESP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            ben_q        <= 4'b0000;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_req_valid) begin
                        req_ready_q <= 1'b0;
                        if (bus.i_req_fence) begin
                            state <= S_FENCE_ISSUE;
                        end else begin
                            addr_q  <= bus.i_req_addr;
                            size_q  <= bus.i_req_size;
                            we_q    <= bus.i_req_we;
                            uns_q   <= bus.i_req_unsigned;
                            ben_q   <= lane_ben(bus.i_req_size, bus.i_req_addr[1:0]);
                            wdata_q <= lane_wdata(bus.i_req_size, bus.i_req_wdata);
                            if (is_misaligned(bus.i_req_size, bus.i_req_addr[1:0])) begin
                                state        <= S_RESP;
                                resp_valid_q <= 1'b1;
                                resp_mis_q   <= 1'b1;
                                resp_rdata_q <= '0;
                            end else begin
                                state <= S_ISSUE;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.i_mem_ready) begin
                        if (we_q) begin
                            state        <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_mis_q   <= 1'b0;
                            resp_rdata_q <= '0;
                        end else begin
                            state <= S_RDATA;
                        end
                    end
                end
                S_RDATA: begin
                    state        <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_mis_q   <= 1'b0;
                    resp_rdata_q <= rd_ext;
                end
                S_FENCE_ISSUE: begin
                    if (bus.i_mem_ready) state <= S_FENCE_BUSY;
                end
                S_FENCE_BUSY: begin
                    // memory drops ready once it starts its sync
                    if (!bus.i_mem_ready) state <= S_FENCE_DONE;
                end
                S_FENCE_DONE: begin
                    if (bus.i_mem_ready) begin
                        state        <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_mis_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                S_RESP: begin
                    state       <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
